rom_fetch_unit: RTL
===================

# rom_fetch_unit

Instruction-fetch front end that acts as the reading end of the instruction ROM interface. It owns the program counter and drives the ROM's `addr`/`sel` pair. It captures the ROM's combinational `dout` into a registered instruction/PC pair, and hands that pair to decode over a valid/ready handshake. It sits between the instruction ROM and the decode stage of the MIPS core, and accepts stall and redirect (branch/jump) requests from the pipeline.

## Interface
Parameters:
- `ADDR_BITS`, default 10: ROM word-address width. Must match the ROM's `ADDR_BITS`.
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset. Must be word aligned.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `rom_addr`, out, ADDR_BITS: ROM word address, equal to `pc[ADDR_BITS+1:2]`.
- `rom_sel`, out, 1: ROM select.
- `rom_dout`, in, 32: ROM read data. Combinational, so it is valid in the same cycle as `rom_addr`/`rom_sel`.
- `stall`, in, 1: freeze fetch. Does not block consumption of an already held instruction.
- `redirect_valid`, in, 1: load a new PC.
- `redirect_pc`, in, 32: target byte address.
- `inst`, out, 32: fetched instruction.
- `inst_pc`, out, 32: byte address of `inst`.
- `inst_valid`, out, 1: `inst`/`inst_pc` hold a valid pair.
- `inst_ready`, in, 1: decode accepts the pair when it and `inst_valid` are both 1.
- `fault`, out, 1: misaligned-redirect trap (see Configuration).

## Operation
- State machine: IDLE, RUN, HALT.
  - IDLE is entered on reset. It moves to RUN unconditionally on the next edge with `rst_n`=1.
  - RUN moves to HALT only on a trapped misaligned redirect.
  - HALT is left only by reset.
- `rom_sel` = (state==RUN) && !stall && !redirect_valid. `rom_addr` always reflects `pc`.
- Define `load` = state==RUN && !stall && !redirect_valid && (!inst_valid || inst_ready).
- On `load`:
  - `inst` <= `rom_dout`.
  - `inst_pc` <= `pc`.
  - `inst_valid` <= 1.
  - `pc` <= `pc + 4`. This is 32-bit modulo arithmetic: 32'hFFFF_FFFC wraps to 0.
- When `load` is 0 and `inst_valid && inst_ready`: `inst_valid` <= 0. `inst`/`inst_pc` keep their values.
- When `inst_valid && !inst_ready`: `inst`, `inst_pc` and `inst_valid` are held stable. No fetch advances.
- Redirect has highest priority in RUN, over stall and handshake:
  - `pc` <= `redirect_pc`.
  - `inst_valid` <= 0. Any unaccepted instruction is flushed.
  - No capture that cycle.
- If a redirect coincides with acceptance (`inst_valid && inst_ready`), the acceptance still counts. The flush only applies to the following cycle.
- PCs above the ROM size alias into the ROM through address truncation. There is no out-of-range detection.
- HALT: `rom_sel`=0 and no captures. The held instruction may still be accepted, after which `inst_valid`=0. Redirects are ignored.

## Timing
- Reset values:
  - `pc`=RESET_PC.
  - `inst`=0, `inst_pc`=0, `inst_valid`=0.
  - `fault`=0.
  - `rom_sel`=0.
  - state IDLE.
- Reset mid-operation overrides everything on that edge.
- Latency:
  - Edge 1 with `rst_n`=1: IDLE to RUN.
  - Edge 2: first `inst_valid`=1 with `inst_pc`=RESET_PC.
- Throughput: one instruction per cycle while `inst_ready`=1 and `stall`=0.
- Redirect: an edge with `redirect_valid`=1 gives `inst_valid`=0 in the following cycle. The target instruction appears valid one edge later, so the redirect bubble is 1 cycle.
- `stall` is sampled every edge. While it is asserted, `pc` is constant.

## Configuration
- `FETCH_MISALIGN_TRAP_EN`, when defined:
  - A redirect in RUN with `redirect_pc[1:0]`!=0 moves to HALT.
  - `fault` <= 1 and stays 1 until reset.
  - `pc` is not updated and `inst_valid` <= 0.
- When not defined:
  - `redirect_pc[1:0]` is masked to 0 and fetch continues normally.
  - `fault` is tied to 0.

## Test plan
- Reset with RESET_PC=0 and ROM words 0..3 = A0,A1,A2,A3; `inst_ready`=1. Expect `inst_valid` first high on the second edge after reset release, then `inst` = A0,A1,A2,A3 on consecutive cycles with `inst_pc` = 0,4,8,12.
- Back-pressure: hold `inst_ready`=0 for 3 cycles while `inst`=A1. Expect `inst`/`inst_pc`/`inst_valid` stable at A1/4/1 and `rom_addr` held at 2. After release, A2 follows the next cycle.
- Redirect to 32'h20 while `inst_ready`=0. Expect `inst_valid`=0 the next cycle, then `inst_pc`=32'h20 with `inst`=ROM[8]. Also check that the redirect wins over simultaneous `stall`=1.
- Stall for 2 cycles with `inst_ready`=1. Expect `inst_valid` to drop after acceptance, `rom_sel`=0, and `pc` frozen. Fetch resumes at the next sequential address.
- Wrap and aliasing:
  - With ADDR_BITS=4, redirect to 32'hFFFF_FFFC. Expect fetch of ROM[15], then `inst_pc`=0 with ROM[0].
  - Redirect to 32'h44. Expect ROM[1] (aliased).
- Misaligned redirect to 32'h6:
  - With `FETCH_MISALIGN_TRAP_EN`: `fault`=1, `rom_sel`=0 permanently, and only reset recovers.
  - Without it: `inst_pc`=4 with ROM[1], and `fault`=0.

Source files
------------

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit
//   Instruction-fetch front end for the MIPS core. Owns the program counter,
//   drives the instruction ROM's addr/sel pair, captures the ROM's
//   combinational read data into a registered inst/inst_pc pair and offers
//   that pair to decode over a valid/ready handshake. Accepts stall and
//   redirect (branch/jump) requests from the pipeline.
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN
//     defined   : a misaligned redirect halts fetch and raises a sticky fault
//     undefined : redirect_pc[1:0] is masked to zero, fault is tied low
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   rom_addr, rom_sel ROM word address (pc[ADDR_BITS+1:2]) and select
//   rom_dout          ROM read data, combinational from rom_addr
//   stall             freeze fetch (held instruction may still be accepted)
//   redirect_valid    load redirect_pc into the PC, flush held instruction
//   redirect_pc       redirect target byte address
//   inst, inst_pc     fetched instruction and its byte address
//   inst_valid        inst/inst_pc hold a valid pair
//   inst_ready        decode accepts the pair when inst_valid is also high
//   fault             misaligned-redirect trap indication

module rom_fetch_unit #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 rom_sel,
    input  logic [31:0]          rom_dout,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          inst,
    output logic [31:0]          inst_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;

    logic        accept;          // decode takes the held pair this cycle
    logic        load;            // capture rom_dout this cycle
    logic        redirect;        // redirect honoured (RUN only)
    logic        trap;            // honoured redirect is misaligned and traps
    logic [31:0] redirect_target;

    assign rom_addr = pc[ADDR_BITS+1:2];

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        rom_sel   = (state == RUN) && !stall && !redirect_valid;
        accept    = inst_valid && inst_ready;
        load      = rom_sel && (!inst_valid || inst_ready);
        redirect  = (state == RUN) && redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_target = redirect_pc;
        trap            = redirect && (redirect_pc[1:0] != 2'b00);
`else
        // Low bits are dropped so fetch always stays word aligned.
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
        trap            = 1'b0;
`endif
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (trap) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                // Redirect beats stall and handshake; an acceptance in this
                // same cycle has already happened, so clearing valid is safe.
                if (!trap) pc <= redirect_target;
                inst_valid <= 1'b0;
            end else if (load) begin
                inst       <= rom_dout;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                pc         <= pc + 32'd4;   // modulo 2^32 wrap is intended
            end else if (accept) begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky until reset: HALT has no exit other than reset either.
    always_ff @(posedge clk) begin
        if (!rst_n)    fault <= 1'b0;
        else if (trap) fault <= 1'b1;
    end
`else
    assign fault = 1'b0;
`endif

endmodule
